lvda_timing_sequencer: RTL and testbench

- Generates the four sub-bit timing drives WDA/XDA/YDA/ZDA that feed the timing distribution buffers. Also produces the bit-time and phase counts that sequence an instruction cycle.
- Owns run/halt/single-step control, so the simulated computer can be started, stopped only on instruction-cycle boundaries, or stepped one cycle at a time.
- Sits between the simulation clock and the timing distribution modules.

---
 rtl/lvda_timing_sequencer.sv | 152 +++++++++++++++
 tb/tb_lvda_timing_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lvda_timing_sequencer.sv
// Sub-bit timing generator (W/X/Y/Z drives) with bit/phase counting and
// run/halt/single-step control that only stops on instruction-cycle boundaries.
//
// state       | meaning
// ST_HALTED   | no cycle in progress, all drives low
// ST_RUNNING  | free-running instruction cycles
// ST_STEPPING | running exactly one instruction cycle
module lvda_timing_sequencer #(
  parameter int CLKS_PER_SUB   = 4,
  parameter int BITS_PER_PHASE = 14,
  parameter int PHASES         = 3
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       RUN,
  input  logic       STEP,
  input  logic       HALT_REQ,
  output logic       WDA,
  output logic       XDA,
  output logic       YDA,
  output logic       ZDA,
  output logic [3:0] BIT,
  output logic [1:0] PHASE,
  output logic       CYCLE_END,
  output logic       HALTED
);

  typedef enum logic [1:0] {ST_HALTED, ST_RUNNING, ST_STEPPING} state_t;

  localparam logic [7:0] SUB_LOAD   = 8'(CLKS_PER_SUB - 1);
  localparam logic [3:0] BIT_LAST   = 4'(BITS_PER_PHASE - 1);
  localparam logic [1:0] PHASE_LAST = 2'(PHASES - 1);

  state_t     state_q, state_d;
  logic [7:0] sub_cnt_q, sub_cnt_d;
  logic [1:0] sub_sel_q, sub_sel_d;
  logic [3:0] bit_q, bit_d;
  logic [1:0] phase_q, phase_d;
  logic       wda_q, wda_d, xda_q, xda_d, yda_q, yda_d, zda_q, zda_d;
  logic       cycle_end_q, cycle_end_d;
  logic       halted_q, halted_d;
  logic       last_clk, start, stop, active_d;

  always_comb begin
    state_d   = state_q;
    sub_cnt_d = sub_cnt_q;
    sub_sel_d = sub_sel_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    start     = 1'b0;
    stop      = 1'b0;
    last_clk  = (state_q != ST_HALTED) && (sub_cnt_q == 8'd0) && (sub_sel_q == 2'd3) &&
                (bit_q == BIT_LAST) && (phase_q == PHASE_LAST);

    case (state_q)
      ST_HALTED: begin
        if (RUN && !HALT_REQ) begin
          state_d = ST_RUNNING;
          start   = 1'b1;
        end else if (STEP && !HALT_REQ) begin
          state_d = ST_STEPPING;
          start   = 1'b1;
        end
      end
      default: begin
        if (last_clk) begin
          // Boundary: only a free-running sequencer with RUN still up continues.
          if (state_q == ST_RUNNING && RUN && !HALT_REQ) begin
            start = 1'b1;
          end else begin
            state_d = ST_HALTED;
            stop    = 1'b1;
          end
        end else if (sub_cnt_q == 8'd0) begin
          sub_cnt_d = SUB_LOAD;
          sub_sel_d = sub_sel_q + 2'd1;
          if (sub_sel_q == 2'd3) begin
            if (bit_q == BIT_LAST) begin
              bit_d   = 4'd0;
              phase_d = phase_q + 2'd1;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end else begin
          sub_cnt_d = sub_cnt_q - 8'd1;
        end
      end
    endcase

    if (start) begin
      sub_cnt_d = SUB_LOAD;
      sub_sel_d = 2'd0;
      bit_d     = 4'd0;
      phase_d   = 2'd0;
    end
    if (stop) begin
      sub_cnt_d = 8'd0;
      sub_sel_d = 2'd0;
      bit_d     = 4'd0;
      phase_d   = 2'd0;
    end

    // Outputs are registered versions of the decoded next state.
    active_d    = (state_d != ST_HALTED);
    wda_d       = active_d && (sub_sel_d == 2'd0);
    xda_d       = active_d && (sub_sel_d == 2'd1);
    yda_d       = active_d && (sub_sel_d == 2'd2);
    zda_d       = active_d && (sub_sel_d == 2'd3);
    cycle_end_d = active_d && (sub_cnt_d == 8'd0) && (sub_sel_d == 2'd3) &&
                  (bit_d == BIT_LAST) && (phase_d == PHASE_LAST);
    halted_d    = !active_d;
  end

  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      state_q     <= ST_HALTED;
      sub_cnt_q   <= 8'd0;
      sub_sel_q   <= 2'd0;
      bit_q       <= 4'd0;
      phase_q     <= 2'd0;
      wda_q       <= 1'b0;
      xda_q       <= 1'b0;
      yda_q       <= 1'b0;
      zda_q       <= 1'b0;
      cycle_end_q <= 1'b0;
      halted_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      sub_cnt_q   <= sub_cnt_d;
      sub_sel_q   <= sub_sel_d;
      bit_q       <= bit_d;
      phase_q     <= phase_d;
      wda_q       <= wda_d;
      xda_q       <= xda_d;
      yda_q       <= yda_d;
      zda_q       <= zda_d;
      cycle_end_q <= cycle_end_d;
      halted_q    <= halted_d;
    end
  end

  assign WDA       = wda_q;
  assign XDA       = xda_q;
  assign YDA       = yda_q;
  assign ZDA       = zda_q;
  assign BIT       = bit_q;
  assign PHASE     = phase_q;
  assign CYCLE_END = cycle_end_q;
  assign HALTED    = halted_q;

endmodule

// File: tb/tb_lvda_timing_sequencer.sv
// Scoreboard bench for lvda_timing_sequencer: default config and a 1/1/1 config
// share stimulus; a cycle-position model predicts every clock's outputs.
module tb_lvda_timing_sequencer;

  logic clk = 1'b0;
  logic rst_b, run, step, halt_req;
  logic [11:0] got0, got1;
  logic        w0, x0, y0, z0, ce0, h0, w1, x1, y1, z1, ce1, h1;
  logic [3:0]  bit0, bit1;
  logic [1:0]  ph0, ph1;

  int n_tests = 0;
  int n_fail  = 0;
  int clk_n   = 0;
  int m_mode [2];
  int m_pos  [2];
  logic [11:0] exp_q0 [$];
  logic [11:0] exp_q1 [$];

  always #5 clk = ~clk;

  lvda_timing_sequencer #(.CLKS_PER_SUB(4), .BITS_PER_PHASE(14), .PHASES(3)) dut0 (
    .SIM_CLK(clk), .SIM_RST(rst_b), .RUN(run), .STEP(step), .HALT_REQ(halt_req),
    .WDA(w0), .XDA(x0), .YDA(y0), .ZDA(z0), .BIT(bit0), .PHASE(ph0),
    .CYCLE_END(ce0), .HALTED(h0));

  lvda_timing_sequencer #(.CLKS_PER_SUB(1), .BITS_PER_PHASE(1), .PHASES(1)) dut1 (
    .SIM_CLK(clk), .SIM_RST(rst_b), .RUN(run), .STEP(step), .HALT_REQ(halt_req),
    .WDA(w1), .XDA(x1), .YDA(y1), .ZDA(z1), .BIT(bit1), .PHASE(ph1),
    .CYCLE_END(ce1), .HALTED(h1));

  assign got0 = {w0, x0, y0, z0, bit0, ph0, ce0, h0};
  assign got1 = {w1, x1, y1, z1, bit1, ph1, ce1, h1};

  function automatic int cfg_c(input int k); return (k == 0) ? 4 : 1; endfunction
  function automatic int cfg_b(input int k); return (k == 0) ? 14 : 1; endfunction
  function automatic int cfg_p(input int k); return (k == 0) ? 3 : 1; endfunction
  function automatic int cfg_len(input int k);
    return cfg_p(k) * cfg_b(k) * 4 * cfg_c(k);
  endfunction

  // Outputs as a function of mode (0 halted, 1 run, 2 step) and clock index in the cycle.
  function automatic logic [11:0] model_vec(input int k, input int mode, input int pos);
    logic [11:0] v;
    int c, b, sub;
    v = '0;
    c = cfg_c(k);
    b = cfg_b(k);
    if (mode == 0) begin
      v[0] = 1'b1;
    end else begin
      sub       = (pos / c) % 4;
      v[11-sub] = 1'b1;
      v[7:4]    = 4'((pos / (4 * c)) % b);
      v[3:2]    = 2'(pos / (4 * c * b));
      v[1]      = (pos == cfg_len(k) - 1);
    end
    return v;
  endfunction

  always @(posedge clk) begin
    clk_n <= clk_n + 1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_b) begin
        m_mode[k] = 0;
        m_pos[k]  = 0;
      end else if (m_mode[k] == 0) begin
        if (run && !halt_req) begin
          m_mode[k] = 1;
          m_pos[k]  = 0;
        end else if (step && !halt_req) begin
          m_mode[k] = 2;
          m_pos[k]  = 0;
        end
      end else if (m_pos[k] == cfg_len(k) - 1) begin
        m_pos[k] = 0;
        if (!(m_mode[k] == 1 && run && !halt_req)) m_mode[k] = 0;
      end else begin
        m_pos[k] = m_pos[k] + 1;
      end
      if (k == 0) exp_q0.push_back(model_vec(k, m_mode[k], m_pos[k]));
      else        exp_q1.push_back(model_vec(k, m_mode[k], m_pos[k]));
    end
  end

  task automatic check_cfg(input int k, input logic [11:0] got);
    logic [11:0] e;
    n_tests++;
    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
      n_fail++;
      $display("FAIL cfg%0d clk %0d scoreboard: no expected entry, got %h", k, clk_n, got);
    end else begin
      e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL cfg%0d clk %0d outputs {WXYZ,BIT,PHASE,CE,HALTED}: got %h want %h",
                 k, clk_n, got, e);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    check_cfg(0, got0);
    check_cfg(1, got1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_b = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    tick(3);
    rst_b = 1'b1;
    tick(2);
    // continuous run over several boundaries, then stop
    run = 1'b1;
    tick(672 * 3 + 10);
    run = 1'b0;
    tick(700);
    // single step with a second ignored step mid-cycle
    step = 1'b1; tick(1); step = 1'b0;
    tick(300);
    step = 1'b1; tick(1); step = 1'b0;
    tick(500);
    // halt request mid-cycle with RUN held high
    run = 1'b1;
    tick(300);
    halt_req = 1'b1;
    tick(800);
    halt_req = 1'b0;
    run = 1'b0;
    tick(700);
    // RUN dropped exactly on the CYCLE_END clock
    run = 1'b1;
    tick(672);
    run = 1'b0;
    tick(20);
    // RUN glitch mid-cycle
    run = 1'b1;
    tick(100);
    run = 1'b0;
    tick(100);
    run = 1'b1;
    tick(1500);
    // reset mid-cycle, then RUN and STEP together
    run = 1'b0;
    rst_b = 1'b0; tick(1); rst_b = 1'b1;
    run = 1'b1; step = 1'b1; tick(1); step = 1'b0;
    tick(1400);
    // randomized control traffic
    for (int i = 0; i < 30; i++) begin
      run      = 1'($urandom_range(0, 1));
      halt_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        step = 1'b1; tick(1); step = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) begin
        rst_b = 1'b0; tick(1); rst_b = 1'b1;
      end
      tick($urandom_range(1, 1200));
    end
    run = 1'b1; halt_req = 1'b0;
    tick(100);
    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
